ins_issue: RTL and testbench

INS_ISSUE -- requirements
Module: ins_issue

---
 rtl/ins_issue.sv | 207 ++++++++++++++++++++
 tb/tb_ins_issue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_issue.sv
// ----------------------------------------------------------------------------
// ins_issue
//
// Instruction issue unit. The host writes instruction words into a FIFO. A
// one-cycle start pulse begins a run that hands run_len words (0 = 256) to a
// controller, one at a time, over a valid/ready handshake. Issues are paced
// by a mandatory idle cycle between offers. Once the last word is accepted,
// the unit waits for the controller to report two consecutive idle samples,
// then pulses done.
//
// Ports
//   clk        : single clock, rising-edge
//   rst        : asynchronous active-low reset (release synchronised inside)
//   wr_valid   : host write request
//   wr_ready   : FIFO not full
//   wr_ins     : host instruction word
//   start      : one-cycle pulse that begins a run (honoured only when idle)
//   run_len    : instructions to issue, sampled on start; 0 means 256
//   ins_valid  : instruction offered to the controller
//   ins_ready  : one-cycle acceptance pulse from the controller
//   ins        : offered instruction (opcode in [INST_W-1:INST_W-2])
//   working    : controller busy flag
//   busy       : run in progress
//   done       : one-cycle pulse at end of run
//   issued_cnt : instructions accepted in the current or last run
//   fifo_cnt   : FIFO occupancy
// ----------------------------------------------------------------------------
module ins_issue #(
  parameter int unsigned INST_W = 64,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [INST_W-1:0]      wr_ins,
  input  logic                   start,
  input  logic [7:0]             run_len,
  output logic                   ins_valid,
  input  logic                   ins_ready,
  output logic [INST_W-1:0]      ins,
  input  logic                   working,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             issued_cnt,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    OFFER,
    GAP,
    DRAIN
  } state_e;

  // --------------------------------------------------------------------------
  // Reset release synchroniser. Assertion is asynchronous everywhere; starts
  // are only honoured once the deasserted reset has passed two flops.
  // --------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       run_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign run_en = rst_sync_q[1];

  // --------------------------------------------------------------------------
  // Instruction FIFO
  // --------------------------------------------------------------------------
  logic [INST_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              push, pop;
  logic [INST_W-1:0] head;

  assign wr_ready = (cnt_q < FULL);
  assign push     = wr_valid && wr_ready;
  // Only an accepted offer consumes the head word.
  assign pop      = ins_valid && ins_ready;
  assign head     = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_ins;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!push && pop) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fifo_cnt = cnt_q;

  // --------------------------------------------------------------------------
  // Issue FSM: state register
  // --------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   w0_seen_q;
  logic [8:0] rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // Issue FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && run_en) state_d = FETCH;
      FETCH:   if (cnt_q != '0) state_d = OFFER;
      OFFER:   if (ins_ready) state_d = (rem_q == 9'd1) ? DRAIN : GAP;
      GAP:     state_d = FETCH;
      DRAIN:   if (!working && w0_seen_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Issue FSM: outputs and datapath controls
  // --------------------------------------------------------------------------
  logic start_run, load, accept, drain_exit;

  always_comb begin
    ins_valid  = (state_q == OFFER);
    busy       = (state_q != IDLE);
    start_run  = (state_q == IDLE) && start && run_en;
    load       = (state_q == FETCH) && (cnt_q != '0);
    accept     = (state_q == OFFER) && ins_ready;
    drain_exit = (state_q == DRAIN) && !working && w0_seen_q;
  end

  // --------------------------------------------------------------------------
  // Run datapath
  // --------------------------------------------------------------------------
  logic [8:0]        rem_d;
  logic [7:0]        issued_q, issued_d;
  logic [INST_W-1:0] ins_q, ins_d;
  logic              w0_seen_d;
  logic              done_q, done_d;

  always_comb begin
    rem_d    = rem_q;
    issued_d = issued_q;
    ins_d    = ins_q;
    if (start_run) begin
      // Nine bits so that run_len = 0 can stand for 256.
      rem_d    = (run_len == 8'd0) ? 9'd256 : {1'b0, run_len};
      issued_d = '0;
    end
    if (load) ins_d = head;
    if (accept) begin
      rem_d    = rem_q - 9'd1;
      issued_d = issued_q + 8'd1;
    end
    // First idle sample of working while draining; a second one ends the run.
    w0_seen_d = (state_q == DRAIN) && !working;
    done_d    = drain_exit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q     <= '0;
      issued_q  <= '0;
      ins_q     <= '0;
      w0_seen_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      issued_q  <= issued_d;
      ins_q     <= ins_d;
      w0_seen_q <= w0_seen_d;
      done_q    <= done_d;
    end
  end

  assign ins        = ins_q;
  assign issued_cnt = issued_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ins_issue.sv
module tb_ins_issue;
  localparam int unsigned INST_W = 64;
  localparam int unsigned DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [INST_W-1:0] wr_ins = '0;
  logic              start = 1'b0;
  logic [7:0]        run_len = '0;
  logic              ins_valid;
  logic              ins_ready = 1'b0;
  logic [INST_W-1:0] ins;
  logic              working = 1'b0;
  logic              busy;
  logic              done;
  logic [7:0]        issued_cnt;
  logic [4:0]        fifo_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ins_issue #(.INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ins(wr_ins),
    .start(start), .run_len(run_len),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
    .working(working), .busy(busy), .done(done),
    .issued_cnt(issued_cnt), .fifo_cnt(fifo_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 0; wr_ins = '0; start = 0; run_len = '0; ins_ready = 0; working = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    tick(); tick();
    rst = 1;
    tick(); tick();
  endtask

  task automatic push_word(input logic [INST_W-1:0] w);
    wr_valid = 1; wr_ins = w;
    tick();
    wr_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; tick();
    rst = 0; #1;
    n_total++; if (ins_valid !== 1'b0) $display("FAIL rst_ins_valid got %b exp 0", ins_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else n_pass++;
    n_total++; if (issued_cnt !== 8'd0) $display("FAIL rst_issued got %0d exp 0", issued_cnt); else n_pass++;
    n_total++; if (fifo_cnt !== 5'd0) $display("FAIL rst_fifo_cnt got %0d exp 0", fifo_cnt); else n_pass++;
    n_total++; if (ins !== 64'd0) $display("FAIL rst_ins got %0h exp 0", ins); else n_pass++;
    n_total++; if (wr_ready !== 1'b1) $display("FAIL rst_wr_ready got %b exp 1", wr_ready); else n_pass++;
    tick(); tick();
    rst = 1;
    tick();
    start = 1; run_len = 8'd1;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL start_during_sync got busy %b exp 0", busy); else n_pass++;
    tick();
    start = 0;
    n_total++; if (busy !== 1'b1) $display("FAIL start_after_sync got busy %b exp 1", busy); else n_pass++;
  endtask

  task automatic test_fifo_order();
    logic [INST_W-1:0] w [3];
    bit seen;
    w[0] = {2'b11, 62'd17};
    w[1] = {2'b00, 62'd34};
    w[2] = {2'b01, 62'd51};
    do_reset();
    for (int i = 0; i < 3; i++) push_word(w[i]);
    n_total++; if (fifo_cnt !== 5'd3) $display("FAIL order_fill got %0d exp 3", fifo_cnt); else n_pass++;
    working = 1; start = 1; run_len = 8'd3;
    tick();
    start = 0;
    n_total++; if (busy !== 1'b1 || ins_valid !== 1'b0) $display("FAIL order_fetch got busy %b valid %b exp 1 0", busy, ins_valid); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++; if (ins_valid !== 1'b1) $display("FAIL order_valid%0d got %b exp 1", k, ins_valid); else n_pass++;
      n_total++; if (ins !== w[k]) $display("FAIL order_data%0d got %0h exp %0h", k, ins, w[k]); else n_pass++;
      tick();
      ins_ready = 1;
      tick();
      ins_ready = 0;
      n_total++; if (ins_valid !== 1'b0) $display("FAIL order_gap%0d got %b exp 0", k, ins_valid); else n_pass++;
      n_total++; if (issued_cnt !== 8'(k + 1)) $display("FAIL order_cnt%0d got %0d exp %0d", k, issued_cnt, k + 1); else n_pass++;
      n_total++; if (ins !== w[k]) $display("FAIL order_hold%0d got %0h exp %0h", k, ins, w[k]); else n_pass++;
      if (k < 2) begin
        tick();
        n_total++; if (ins_valid !== 1'b0) $display("FAIL order_fetchlow%0d got %b exp 0", k, ins_valid); else n_pass++;
      end
    end
    n_total++; if (fifo_cnt !== 5'd0) $display("FAIL order_empty got %0d exp 0", fifo_cnt); else n_pass++;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || !busy) seen = 1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL drain_hold got early end %b exp 0", seen); else n_pass++;
    working = 0;
    tick();
    n_total++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL drain_p1 got done %b busy %b exp 0 1", done, busy); else n_pass++;
    tick();
    n_total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL drain_p2 got done %b busy %b exp 1 0", done, busy); else n_pass++;
    tick();
    n_total++; if (done !== 1'b0) $display("FAIL done_pulse got %b exp 0", done); else n_pass++;
    n_total++; if (issued_cnt !== 8'd3) $display("FAIL issued_hold got %0d exp 3", issued_cnt); else n_pass++;
  endtask

  task automatic test_empty_wait();
    bit seen;
    do_reset();
    start = 1; run_len = 8'd2;
    tick();
    start = 0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin start = 1; run_len = 8'd5; end
      tick();
      start = 0;
      if (ins_valid) seen = 1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL empty_novalid got %b exp 0", seen); else n_pass++;
    wr_valid = 1; wr_ins = 64'hA5;
    tick();
    wr_valid = 0;
    n_total++; if (ins_valid !== 1'b0) $display("FAIL empty_w1 got %b exp 0", ins_valid); else n_pass++;
    tick();
    n_total++; if (ins_valid !== 1'b1 || ins !== 64'hA5) $display("FAIL empty_w2 got %b %0h exp 1 a5", ins_valid, ins); else n_pass++;
    ins_ready = 1;
    tick();
    ins_ready = 0;
    n_total++; if (issued_cnt !== 8'd1 || fifo_cnt !== 5'd0) $display("FAIL empty_ack got %0d %0d exp 1 0", issued_cnt, fifo_cnt); else n_pass++;
    ins_ready = 1;
    for (int i = 0; i < 3; i++) tick();
    ins_ready = 0;
    n_total++; if (issued_cnt !== 8'd1) $display("FAIL ready_ignored got %0d exp 1", issued_cnt); else n_pass++;
    n_total++; if (ins_valid !== 1'b0 || busy !== 1'b1) $display("FAIL fetch_wait got %b %b exp 0 1", ins_valid, busy); else n_pass++;
    push_word(64'h5A);
    tick();
    n_total++; if (ins_valid !== 1'b1 || ins !== 64'h5A) $display("FAIL empty_w3 got %b %0h exp 1 5a", ins_valid, ins); else n_pass++;
    ins_ready = 1;
    tick();
    ins_ready = 0;
    tick();
    n_total++; if (done !== 1'b0) $display("FAIL empty_done_early got %b exp 0", done); else n_pass++;
    tick();
    n_total++; if (done !== 1'b1 || issued_cnt !== 8'd2) $display("FAIL empty_done got %b %0d exp 1 2", done, issued_cnt); else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) push_word(64'h100 + 64'(i));
    n_total++; if (fifo_cnt !== 5'd16 || wr_ready !== 1'b0) $display("FAIL full_fill got %0d %b exp 16 0", fifo_cnt, wr_ready); else n_pass++;
    push_word(64'hDEAD);
    n_total++; if (fifo_cnt !== 5'd16) $display("FAIL full_drop got %0d exp 16", fifo_cnt); else n_pass++;
    start = 1; run_len = 8'd2;
    tick();
    start = 0;
    tick();
    n_total++; if (ins !== 64'h100) $display("FAIL full_head got %0h exp 100", ins); else n_pass++;
    ins_ready = 1;
    tick();
    ins_ready = 0;
    n_total++; if (fifo_cnt !== 5'd15 || wr_ready !== 1'b1) $display("FAIL full_pop got %0d %b exp 15 1", fifo_cnt, wr_ready); else n_pass++;
    tick(); tick();
    n_total++; if (ins !== 64'h101) $display("FAIL full_second got %0h exp 101", ins); else n_pass++;
    ins_ready = 1; wr_valid = 1; wr_ins = 64'hBEEF;
    tick();
    ins_ready = 0; wr_valid = 0;
    n_total++; if (fifo_cnt !== 5'd15) $display("FAIL simul_wr_pop got %0d exp 15", fifo_cnt); else n_pass++;
    push_word(64'hCAFE);
    n_total++; if (fifo_cnt !== 5'd16 || wr_ready !== 1'b0) $display("FAIL full_refill got %0d %b exp 16 0", fifo_cnt, wr_ready); else n_pass++;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    working = 1;
    for (int i = 0; i < 5; i++) push_word(64'h200 + 64'(i));
    start = 1; run_len = 8'd5;
    tick();
    start = 0;
    tick();
    n_total++; if (ins_valid !== 1'b1 || fifo_cnt !== 5'd5) $display("FAIL mid_pre got %b %0d exp 1 5", ins_valid, fifo_cnt); else n_pass++;
    #2 rst = 0;
    #1;
    n_total++; if (ins_valid !== 1'b0 || busy !== 1'b0) $display("FAIL mid_valid got %b %b exp 0 0", ins_valid, busy); else n_pass++;
    n_total++; if (fifo_cnt !== 5'd0 || ins !== 64'd0) $display("FAIL mid_fifo got %0d %0h exp 0 0", fifo_cnt, ins); else n_pass++;
    seen = 0;
    working = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 1) rst = 1;
      if (done) seen = 1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL mid_nodone got %b exp 0", seen); else n_pass++;
  endtask

  task automatic test_run256();
    int  wn, acc, order_err;
    bit  got_done, push_now, acc_now, busy_at_done;
    do_reset();
    start = 1; run_len = 8'd0;
    tick();
    start = 0;
    wn = 0; acc = 0; order_err = 0; got_done = 0; busy_at_done = 1;
    for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
      wr_valid = 1; wr_ins = 64'(wn);
      push_now = wr_ready;
      acc_now  = ins_valid;
      ins_ready = ins_valid;
      if (acc_now && ins !== 64'(acc)) order_err++;
      tick();
      if (push_now) wn++;
      if (acc_now) acc++;
      if (done) begin got_done = 1; busy_at_done = busy; end
    end
    wr_valid = 0; ins_ready = 0;
    n_total++; if (got_done !== 1'b1) $display("FAIL run256_timeout got done %b exp 1", got_done); else n_pass++;
    n_total++; if (acc !== 256) $display("FAIL run256_accepts got %0d exp 256", acc); else n_pass++;
    n_total++; if (issued_cnt !== 8'd0) $display("FAIL run256_wrap got %0d exp 0", issued_cnt); else n_pass++;
    n_total++; if (order_err !== 0) $display("FAIL run256_order got %0d errors exp 0", order_err); else n_pass++;
    n_total++; if (busy_at_done !== 1'b0) $display("FAIL run256_busy got %b exp 0", busy_at_done); else n_pass++;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fifo_order();
    test_empty_wait();
    test_full();
    test_reset_mid();
    test_run256();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
